uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. the result streamer and the status/ack generator.
- Arbitrates round-robin at packet granularity: once granted, a requester keeps the transmitter until its byte flagged last has been fully sent.
- Drives the transmitter's start/message inputs and sequences each byte from its busy output.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, bits per UART frame; must match the transmitter's UART_BITS_TRANSFERED.
- LEN_W, 8, width of the per-packet byte counter; saturates at all-ones.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  marks the final byte of a packet.
- req_ready  out  NUM_REQ  byte accepted on a cycle where valid & ready are both high.
- grant_valid  out  1  a packet is in progress.
- grant_id  out  $clog2(NUM_REQ) (min 1)  owner of the current packet.
- pkt_done  out  1  one-cycle pulse when the last byte of a packet leaves the transmitter.
- pkt_len  out  LEN_W  byte count of the packet just completed; valid while pkt_done is high.
- tx_start  out  1  start pulse to the transmitter.
- tx_message  out  DATA_W  byte to transmit; registered.
- tx_busy  in  1  transmitter busy.

Behaviour:
- Reset values: state ARB, rr_ptr=0, grant_valid=0, grant_id=0, req_ready=0, tx_start=0, tx_message=0, pkt_done=0, pkt_len=0, byte counter=0.
- Reset mid-packet aborts the packet immediately. No pkt_done is issued. The transmitter resets on the same rst.
- req_ready is combinational from registered state only: req_ready[i] = (state==FETCH) && (grant_id==i). At most one bit is high.
- ARB:
  - If no req_valid bit is set, stay in ARB.
  - Otherwise the winner is the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Set grant_id=winner and grant_valid=1, clear the byte counter, go to FETCH.
  - A requester raising valid in the same cycle as ARB is eligible.
- FETCH:
  - If req_valid[grant_id] is high, latch req_data slice into tx_message and req_last into last_q, increment the byte counter (saturating), and go to SEND.
  - If it is low, wait indefinitely. The packet lock is held; other requesters are not served.
- SEND:
  - While tx_busy is high, wait.
  - When tx_busy is low, assert tx_start for exactly this one cycle and go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy=1, which the transmitter raises the cycle after start, then go to WAIT_DONE. tx_start is 0.
- WAIT_DONE: wait for tx_busy=0, then:
  - If last_q is set: pulse pkt_done for one cycle with pkt_len=counter, set grant_valid=0, set rr_ptr=(grant_id+1) mod NUM_REQ, go to ARB.
  - Otherwise go to FETCH.
- tx_message is stable from SEND until the next FETCH acceptance.
- Minimum gap between successive bytes of one packet: 3 clk cycles after busy falls (FETCH, SEND, ACK edge) plus transmitter latency. No byte is overlapped or dropped.
- Simultaneous requests: round-robin only. A requester that just finished has lowest priority next time.
- Requester contract: valid must be held with stable data until ready. A requester may deassert valid between bytes, which stalls its own packet.
- Single-byte packet (req_last on the first byte) is legal; pkt_len=1.
- Byte counter saturates at 2^LEN_W-1 and never wraps.

Test Plan:
- Single requester 0 sends 3 bytes 0x55, 0xA3, 0x0F (last on 0x0F) -> serial line shows the three frames in order; exactly 3 tx_start pulses; one pkt_done with pkt_len=3, grant_id=0.
- Req 0 and req 1 valid in the same cycle after reset, each sending a 2-byte packet -> req 0 is served first (rr_ptr=0) and its packet completes without interleaving; then req 1 is served; pkt_done pulses twice with ids 0 then 1.
- Req 1 streams packets back-to-back while req 0 holds valid -> grants alternate 0, 1, 0, ...; neither requester starves.
- Owner deasserts valid for 50 cycles mid-packet while req 1 is valid -> grant stays on req 0; no tx_start in the gap; req 1 waits until req 0's last byte completes.
- tx_busy forced high externally on entry to SEND -> tx_start stays 0 until busy falls, then exactly one pulse.
- rst asserted during WAIT_DONE -> all outputs return to reset values asynchronously; no pkt_done; the next packet after reset is arbitrated from rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one UART transmitter among
// NUM_REQ byte-stream requesters and sequences each byte from tx_busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      pkt_done,
  output logic [LEN_W-1:0]          pkt_len,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_message,
  input  logic                      tx_busy
);

  typedef enum logic [2:0] {ARB, FETCH, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [LEN_W-1:0] cnt;
  logic            last_q;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  int              idx;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign req_ready[g] = (state == FETCH) && (grant_id == ID_W'(g));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      tx_start    <= 1'b0;
      tx_message  <= '0;
      pkt_done    <= 1'b0;
      pkt_len     <= '0;
      cnt         <= '0;
      last_q      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      pkt_done <= 1'b0;
      case (state)
        ARB: if (win_found) begin
          grant_id    <= win_id;
          grant_valid <= 1'b1;
          cnt         <= '0;
          state       <= FETCH;
        end
        FETCH: if (req_valid[grant_id]) begin
          tx_message <= req_data[int'(grant_id)*DATA_W +: DATA_W];
          last_q     <= req_last[grant_id];
          if (cnt != '1) cnt <= cnt + 1'b1;
          state      <= SEND;
        end
        SEND: if (!tx_busy) begin
          tx_start <= 1'b1;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: if (tx_busy) state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) begin
          if (last_q) begin
            pkt_done    <= 1'b1;
            pkt_len     <= cnt;
            grant_valid <= 1'b0;
            rr_ptr      <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            state       <= ARB;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level round-robin model, simple busy-timer
// transmitter, per-cycle compare against the model plus literal pins.
module tb_uart_tx_arbiter;
  localparam int N = 3, DW = 8, LW = 3, IW = 2, FRAME = 6;
  localparam logic [N-1:0] ONE = 1;

  logic            clk = 1'b0, rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_last = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic            grant_valid, pkt_done, tx_start, tx_busy;
  logic [IW-1:0]   grant_id;
  logic [LW-1:0]   pkt_len;
  logic [DW-1:0]   tx_message;
  logic            force_busy = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant_valid(grant_valid),
    .grant_id(grant_id), .pkt_done(pkt_done), .pkt_len(pkt_len),
    .tx_start(tx_start), .tx_message(tx_message), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: busy from the cycle after start for FRAME cycles.
  int tx_cnt;
  always @(posedge clk or posedge rst)
    if (rst) tx_cnt <= 0;
    else if (tx_start) tx_cnt <= FRAME;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  assign tx_busy = (tx_cnt != 0) || force_busy;

  typedef struct {logic [7:0] d; logic last; int gap;} sbyte_t;
  typedef struct {int id; logic [7:0] d;} eb_t;
  typedef struct {int id; int len;} pkt_t;

  sbyte_t drv_q[N][$];
  sbyte_t pend[N][$];
  eb_t    exp_b[$];
  pkt_t   exp_p[$];
  int     gap_cnt[N];
  logic [N-1:0] fire_pend = '0;
  int     model_rr = 0;
  int     checks = 0, failures = 0;
  int     total_starts = 0;
  logic [7:0] sent_q[$];
  int     done_ids[$], done_lens[$];
  logic   prev_busy = 1'b0, prev_start = 1'b0, prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Requester drivers: present head byte after its gap, pop once accepted.
  always @(negedge clk) begin
    if (rst) begin
      fire_pend = '0;
      req_valid = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (fire_pend[i]) begin
          drv_q[i].delete(0);
          gap_cnt[i] = 0;
        end
      for (int i = 0; i < N; i++) begin
        if (drv_q[i].size() > 0 && gap_cnt[i] >= drv_q[i][0].gap) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = drv_q[i][0].d;
          req_last[i] = drv_q[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          if (drv_q[i].size() > 0) gap_cnt[i]++;
        end
      end
      fire_pend = req_valid & req_ready;
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_owner_only", 32'(req_ready & ~(ONE << grant_id)), 0);
      if (req_ready != '0) chk("ready_needs_grant", 32'(grant_valid), 1);
      if (grant_valid)
        chk("grant_id_model", 32'(grant_id), exp_p.size() > 0 ? exp_p[0].id : 32'hff);
      if (tx_start) begin
        total_starts++;
        sent_q.push_back(tx_message);
        chk("tx_start_single", 32'(prev_start), 0);
        chk("start_after_idle", 32'(prev_busy), 0);
        if (exp_b.size() > 0) begin
          chk("tx_owner", 32'(grant_id), exp_b[0].id);
          chk("tx_message", 32'(tx_message), 32'(exp_b[0].d));
          exp_b.delete(0);
        end else chk("tx_start_expected", exp_b.size(), 1);
      end
      if (pkt_done) begin
        chk("pkt_done_single", 32'(prev_done), 0);
        chk("done_grant_clear", 32'(grant_valid), 0);
        done_ids.push_back(int'(grant_id));
        done_lens.push_back(int'(pkt_len));
        if (exp_p.size() > 0) begin
          chk("done_id", 32'(grant_id), exp_p[0].id);
          chk("done_len", 32'(pkt_len), exp_p[0].len);
          exp_p.delete(0);
        end else chk("pkt_done_expected", exp_p.size(), 1);
      end
    end
    prev_busy  = tx_busy;
    prev_start = tx_start;
    prev_done  = pkt_done;
  end

  task automatic add(input int i, input logic [7:0] d, input logic last, input int gap = 0);
    sbyte_t b;
    b.d = d; b.last = last; b.gap = gap;
    drv_q[i].push_back(b);
    pend[i].push_back(b);
  endtask

  // Packet-level model: each packet goes out whole; next owner is the first
  // requester with a pending packet at or after the pointer.
  task automatic plan();
    int w, n;
    eb_t e;
    pkt_t p;
    forever begin
      w = -1;
      for (int k = 0; k < N && w < 0; k++)
        if (pend[(model_rr + k) % N].size() > 0) w = (model_rr + k) % N;
      if (w < 0) break;
      n = 0;
      forever begin
        e.id = w; e.d = pend[w][0].d;
        exp_b.push_back(e);
        n++;
        if (pend[w][0].last) begin pend[w].delete(0); break; end
        pend[w].delete(0);
      end
      p.id = w; p.len = (n > (1 << LW) - 1) ? (1 << LW) - 1 : n;
      exp_p.push_back(p);
      model_rr = (w + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    force_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete(); pend[i].delete(); gap_cnt[i] = 0;
    end
    exp_b.delete(); exp_p.delete();
    sent_q.delete(); done_ids.delete(); done_lens.delete();
    model_rr = 0;
    #1;
    chk("rst_grant_valid", 32'(grant_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_message", 32'(tx_message), 0);
    chk("rst_pkt_done", 32'(pkt_done), 0);
    chk("rst_pkt_len", 32'(pkt_len), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    logic busy_q;
    busy_q = 1'b1;
    while (busy_q && n < max) begin
      @(negedge clk);
      n++;
      busy_q = (exp_p.size() != 0) || (exp_b.size() != 0);
      for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) busy_q = 1'b1;
    end
    chk("finished_in_time", 32'(n < max), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_starts(input int k, input int max);
    int n = 0;
    while (total_starts < k && n < max) begin @(negedge clk); n++; end
    chk("start_in_time", 32'(total_starts >= k), 1);
  endtask

  int s0;
  initial begin
    // 1: single requester, three bytes
    do_reset();
    s0 = total_starts;
    add(0, 8'h55, 0); add(0, 8'hA3, 0); add(0, 8'h0F, 1);
    plan();
    wait_idle(500);
    chk("t1_starts", total_starts - s0, 3);
    chk("t1_b0", sent_q.size() > 0 ? 32'(sent_q[0]) : 32'hfff, 32'h55);
    chk("t1_b1", sent_q.size() > 1 ? 32'(sent_q[1]) : 32'hfff, 32'hA3);
    chk("t1_b2", sent_q.size() > 2 ? 32'(sent_q[2]) : 32'hfff, 32'h0F);
    chk("t1_len", done_lens.size() > 0 ? done_lens[0] : -1, 3);
    chk("t1_id", done_ids.size() > 0 ? done_ids[0] : -1, 0);

    // 2: simultaneous 2-byte packets from 0 and 1
    do_reset();
    add(1, 8'hB1, 0); add(1, 8'hB2, 1);
    add(0, 8'hA1, 0); add(0, 8'hA2, 1);
    plan();
    wait_idle(500);
    chk("t2_ndone", done_ids.size(), 2);
    chk("t2_first", done_ids.size() > 0 ? done_ids[0] : -1, 0);
    chk("t2_second", done_ids.size() > 1 ? done_ids[1] : -1, 1);
    chk("t2_no_interleave", sent_q.size() > 1 ? 32'(sent_q[1]) : 32'hfff, 32'hA2);

    // 3: back-to-back packets, grants must alternate
    do_reset();
    for (int p = 0; p < 3; p++) begin
      add(0, 8'(8'h10 + p), 0); add(0, 8'(8'h20 + p), 1);
      add(1, 8'(8'h30 + p), 1);
    end
    plan();
    wait_idle(1500);
    chk("t3_ndone", done_ids.size(), 6);
    for (int p = 0; p < 6; p++)
      chk("t3_alternate", done_ids.size() > p ? done_ids[p] : -1, p % 2);

    // 4: owner stalls 50 cycles mid-packet while req 1 waits
    do_reset();
    add(0, 8'hC1, 0); add(0, 8'hC2, 0, 50); add(0, 8'hC3, 1);
    add(1, 8'hD1, 1);
    plan();
    wait_starts(total_starts + 1, 100);
    repeat (10) @(negedge clk);
    s0 = total_starts;
    repeat (30) @(negedge clk);
    chk("t4_no_start_in_gap", total_starts - s0, 0);
    chk("t4_grant_held", 32'({grant_valid, grant_id}), 32'({1'b1, 2'd0}));
    wait_idle(800);
    chk("t4_order", done_ids.size() > 1 ? done_ids[1] : -1, 1);

    // 5: transmitter busy from outside while SEND waits
    do_reset();
    force_busy = 1'b1;
    s0 = total_starts;
    add(0, 8'h3C, 1);
    plan();
    repeat (30) @(negedge clk);
    chk("t5_held_off", total_starts - s0, 0);
    @(posedge clk);
    #1 force_busy = 1'b0;
    wait_idle(300);
    chk("t5_one_start", total_starts - s0, 1);
    chk("t5_single_len", done_lens.size() > 0 ? done_lens[0] : -1, 1);

    // 6: reset inside WAIT_DONE aborts; pointer restarts at 0
    do_reset();
    add(0, 8'h11, 1);
    plan();
    wait_idle(300);
    s0 = total_starts;
    add(1, 8'h22, 0); add(1, 8'h33, 1);
    plan();
    wait_starts(s0 + 1, 100);
    repeat (3) @(negedge clk);
    do_reset();
    add(1, 8'h66, 1);
    add(0, 8'h44, 1);
    plan();
    wait_idle(400);
    chk("t6_first_after_rst", done_ids.size() > 0 ? done_ids[0] : -1, 0);
    chk("t6_second_after_rst", done_ids.size() > 1 ? done_ids[1] : -1, 1);

    // 7: counter saturates at 2^LEN_W-1
    do_reset();
    for (int b = 0; b < 10; b++) add(2, 8'(8'h80 + b), b == 9);
    plan();
    wait_idle(1000);
    chk("t7_sat_len", done_lens.size() > 0 ? done_lens[0] : -1, 7);
    chk("t7_sat_id", done_ids.size() > 0 ? done_ids[0] : -1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
